// File: rtl/colour_palette_mux.sv
// Priority colour-index mux with a double-buffered palette lookup and 2-stage registered RGB output.
// Define COLOUR_PALETTE_WR_EN to enable the programmable shadow bank and frame-synchronous commit.
module colour_palette_mux #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = 4,
  parameter int CH_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_en,
  input  logic [NUM_SRC*IDX_W-1:0] colour,
  input  logic [NUM_SRC-2:0]       sel,
  input  logic                     backporch,
  input  logic                     viewport_active,
  input  logic [IDX_W-1:0]         border_idx,
  input  logic                     frame_start,
  input  logic                     pal_wr_en,
  input  logic [IDX_W-1:0]         pal_addr,
  input  logic [3*CH_W-1:0]        pal_data,
  input  logic                     pal_commit,
  output logic                     pal_pending,
  output logic                     pal_done,
  output logic [3*CH_W-1:0]        rgb,
  output logic                     commit_state
);

  localparam int DEPTH = 2 ** IDX_W;

  // Default table is stored as 3 bits per channel and bit-replicated MSB-first to CH_W.
  function automatic logic [3*CH_W-1:0] def_entry(input int i);
    logic [8:0] v;
    logic [2:0] ch;
    logic [3*CH_W-1:0] e;
    case (i)
      0:  v = 9'b001001001;
      1:  v = 9'b001111000;
      2:  v = 9'b111111000;
      3:  v = 9'b010001111;
      4:  v = 9'b110000010;
      5:  v = 9'b111111111;
      6:  v = 9'b001111100;
      7:  v = 9'b111001111;
      8:  v = 9'b111100000;
      9:  v = 9'b111110010;
      10: v = 9'b000010000;
      11: v = 9'b010001001;
      14: v = 9'b000010000;
      default: v = 9'b000000000;
    endcase
    e = '0;
    for (int c = 0; c < 3; c++) begin
      ch = v[8-3*c -: 3];
      for (int j = 0; j < CH_W; j++)
        e[(3-c)*CH_W-1-j] = ch[2-(j%3)];
    end
    return e;
  endfunction

  logic [IDX_W-1:0]  pix_idx;
  logic [IDX_W-1:0]  idx_q;
  logic              blank_q;
  logic [3*CH_W-1:0] lookup;

  // Lowest set select bit wins; iterate downward so lower sources overwrite higher ones.
  always_comb begin
    pix_idx = colour[(NUM_SRC-1)*IDX_W +: IDX_W];
    for (int k = NUM_SRC-2; k >= 0; k--)
      if (sel[k]) pix_idx = colour[k*IDX_W +: IDX_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      blank_q <= 1'b0;
      rgb     <= '0;
    end else if (pix_en) begin
      blank_q <= backporch;
      idx_q   <= viewport_active ? pix_idx : border_idx;
      rgb     <= blank_q ? '0 : lookup;
    end
  end

`ifdef COLOUR_PALETTE_WR_EN
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t            state_q;
  logic [3*CH_W-1:0] active [DEPTH];
  logic [3*CH_W-1:0] shadow [DEPTH];

  assign lookup       = active[idx_q];
  assign commit_state = (state_q == PENDING);

  // The copy reads shadow before this edge's write lands, so a coincident write waits for the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pal_pending <= 1'b0;
      pal_done    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        active[i] <= def_entry(i);
        shadow[i] <= def_entry(i);
      end
    end else begin
      pal_done <= 1'b0;
      if (pal_wr_en) shadow[pal_addr] <= pal_data;
      case (state_q)
        IDLE: begin
          if (pal_commit) begin
            state_q     <= PENDING;
            pal_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_start && !pal_commit) begin
            for (int i = 0; i < DEPTH; i++) active[i] <= shadow[i];
            pal_done    <= 1'b1;
            pal_pending <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic unused_wr_inputs;

  assign unused_wr_inputs = ^{frame_start, pal_wr_en, pal_addr, pal_data, pal_commit};
  assign lookup           = def_entry(int'(idx_q));
  assign pal_pending      = 1'b0;
  assign pal_done         = 1'b0;
  assign commit_state     = 1'b0;
`endif

endmodule

// File: tb/tb_colour_palette_mux.sv
// Directed bench for colour_palette_mux: pixel mux/priority/border/blank, stall, and palette commit.
module tb_colour_palette_mux;
  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [11:0] colour;
  logic [1:0]  sel;
  logic        backporch;
  logic        viewport_active;
  logic [3:0]  border_idx;
  logic        frame_start;
  logic        pal_wr_en;
  logic [3:0]  pal_addr;
  logic [8:0]  pal_data;
  logic        pal_commit;
  logic        pal_pending;
  logic        pal_done;
  logic [8:0]  rgb;
  logic        commit_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;
  logic [8:0] def_tab [16];

`ifdef COLOUR_PALETTE_WR_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  colour_palette_mux #(.NUM_SRC(3), .IDX_W(4), .CH_W(3)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .colour(colour), .sel(sel),
    .backporch(backporch), .viewport_active(viewport_active), .border_idx(border_idx),
    .frame_start(frame_start), .pal_wr_en(pal_wr_en), .pal_addr(pal_addr),
    .pal_data(pal_data), .pal_commit(pal_commit), .pal_pending(pal_pending),
    .pal_done(pal_done), .rgb(rgb), .commit_state(commit_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PixEn cycle; once two pixels are queued the older one is due on rgb.
  task automatic pix(input string tag, input logic [11:0] c, input logic [1:0] s,
                     input logic bp, input logic va, input logic [3:0] b, input logic [8:0] exp);
    @(negedge clk);
    pix_en = 1'b1; colour = c; sel = s; backporch = bp; viewport_active = va; border_idx = b;
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() >= 2) begin
      last_exp = exp_q.pop_front();
      chk(tag, rgb, last_exp);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      pix_en = 1'b1;
      tick();
      last_exp = exp_q.pop_front();
      chk(tag, rgb, last_exp);
    end
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    @(negedge clk);
    pal_wr_en = 1'b1; pal_addr = a; pal_data = d;
    tick();
    @(negedge clk);
    pal_wr_en = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    pal_commit = 1'b1;
    tick();
    @(negedge clk);
    pal_commit = 1'b0;
  endtask

  task automatic fstart(input string tag, input logic exp_done);
    @(negedge clk);
    frame_start = 1'b1;
    tick();
    chk({tag, "_done"}, {8'd0, pal_done}, {8'd0, exp_done});
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic idx1(input string tag, input logic [8:0] exp);
    pix(tag, 12'h001, 2'b01, 1'b0, 1'b1, 4'h0, exp);
    drain(tag);
  endtask

  initial begin
    logic [11:0] rc;
    logic [1:0]  rs;
    logic [3:0]  ri;
    def_tab = '{9'b001001001, 9'b001111000, 9'b111111000, 9'b010001111,
                9'b110000010, 9'b111111111, 9'b001111100, 9'b111001111,
                9'b111100000, 9'b111110010, 9'b000010000, 9'b010001001,
                9'b000000000, 9'b000000000, 9'b000010000, 9'b000000000};
    reset = 1'b1; pix_en = 1'b0; colour = '0; sel = '0; backporch = 1'b0;
    viewport_active = 1'b1; border_idx = '0; frame_start = 1'b0; pal_wr_en = 1'b0;
    pal_addr = '0; pal_data = '0; pal_commit = 1'b0;
    repeat (3) tick();
    chk("reset_rgb", rgb, 9'd0);
    chk("reset_pending", {8'd0, pal_pending}, 9'd0);
    chk("reset_done", {8'd0, pal_done}, 9'd0);
    @(negedge clk);
    reset = 1'b0;

    pix("src0_idx1", 12'h001, 2'b01, 1'b0, 1'b1, 4'h0, 9'b001111000);
    pix("src2_idx4", 12'h400, 2'b00, 1'b0, 1'b1, 4'h0, 9'b110000010);
    pix("prio_sel11", 12'h432, 2'b11, 1'b0, 1'b1, 4'h0, 9'b111111000);
    pix("prio_sel10", 12'h432, 2'b10, 1'b0, 1'b1, 4'h0, 9'b010001111);
    pix("border_e", 12'h432, 2'b11, 1'b0, 1'b0, 4'hE, 9'b000010000);
    pix("blank", 12'h555, 2'b01, 1'b1, 1'b1, 4'h5, 9'b000000000);
    pix("blank_border", 12'h555, 2'b00, 1'b1, 1'b0, 4'h9, 9'b000000000);
    for (int n = 0; n < 8; n++) begin
      rc = 12'($urandom_range(0, 4095));
      rs = 2'($urandom_range(0, 3));
      ri = rs[0] ? rc[3:0] : (rs[1] ? rc[7:4] : rc[11:8]);
      pix("rand_pix", rc, rs, 1'b0, 1'b1, 4'h0, def_tab[ri]);
    end
    pix("pre_stall", 12'h009, 2'b01, 1'b0, 1'b1, 4'h0, 9'b111110010);

    // Stall: inputs churn with PixEn low, rgb must hold the last delivered pixel.
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      pix_en = 1'b0; colour = 12'($urandom_range(0, 4095)); sel = 2'($urandom_range(0, 3));
      backporch = 1'($urandom_range(0, 1)); viewport_active = 1'($urandom_range(0, 1));
      tick();
      chk("stall_hold", rgb, last_exp);
    end
    pix("resume_a", 12'h005, 2'b01, 1'b0, 1'b1, 4'h0, 9'b111111111);
    pix("resume_b", 12'h007, 2'b01, 1'b0, 1'b1, 4'h0, 9'b111001111);
    drain("resume_drain");

    // Commit held off until FrameStart.
    wr(4'h1, 9'b101010101);
    commit();
    chk("commit_pending", {8'd0, pal_pending}, {8'd0, WR});
    repeat (10) tick();
    idx1("pre_frame_idx1", 9'b001111000);
    chk("still_pending", {8'd0, pal_pending}, {8'd0, WR});
    fstart("frame1", WR);
    chk("frame1_pending", {8'd0, pal_pending}, 9'd0);
    tick();
    chk("frame1_done_pulse", {8'd0, pal_done}, 9'd0);
    idx1("post_frame_idx1", WR ? 9'b101010101 : 9'b001111000);

    // Commit coincident with FrameStart from IDLE is deferred to the next frame.
    wr(4'h1, 9'b000000111);
    @(negedge clk);
    pal_commit = 1'b1; frame_start = 1'b1;
    tick();
    chk("same_cycle_done", {8'd0, pal_done}, 9'd0);
    chk("same_cycle_pending", {8'd0, pal_pending}, {8'd0, WR});
    @(negedge clk);
    pal_commit = 1'b0; frame_start = 1'b0;
    idx1("same_cycle_idx1", WR ? 9'b101010101 : 9'b001111000);
    fstart("frame2", WR);
    idx1("frame2_idx1", WR ? 9'b000000111 : 9'b001111000);

    // Write landing on the copy edge: active gets the old shadow value.
    commit();
    @(negedge clk);
    frame_start = 1'b1; pal_wr_en = 1'b1; pal_addr = 4'h1; pal_data = 9'b111000111;
    tick();
    chk("wr_copy_done", {8'd0, pal_done}, {8'd0, WR});
    @(negedge clk);
    frame_start = 1'b0; pal_wr_en = 1'b0;
    idx1("wr_copy_old", WR ? 9'b000000111 : 9'b001111000);
    commit();
    fstart("frame3", WR);
    idx1("wr_copy_new", WR ? 9'b111000111 : 9'b001111000);

    // Reset while pending abandons the commit and restores defaults.
    wr(4'h1, 9'b010101010);
    commit();
    chk("rst_pending_before", {8'd0, pal_pending}, {8'd0, WR});
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst_pending_after", {8'd0, pal_pending}, 9'd0);
    chk("rst_rgb", rgb, 9'd0);
    @(negedge clk);
    reset = 1'b0;
    fstart("frame_after_rst", 1'b0);
    idx1("rst_idx1", 9'b001111000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
